bidir_bus_ctrl: RTL and testbench
=================================

BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, pad bus width in bits; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 1..4.
REQ-003 Parameter TURN_CYCLES, default 1, dead (all-high-Z) cycles at each bus direction change; legal range 0..7.
REQ-004 clk  input  1  single clock for all flops; the block SHALL use one clock; no other clock port.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 drv_req  input  1  fabric requests to drive the pad bus; level-sensitive.
REQ-007 drv_data  input  WIDTH  data to drive; captured when drv_ack=1.
REQ-008 drv_ack  output  1  drv_data captured into the output register this cycle.
REQ-009 rd_data  output  WIDTH  synchronised pad value (last synchroniser stage).
REQ-010 rd_valid  output  1  rd_data reflects an undriven (by this block) bus and has settled.
REQ-011 bus_dir  output  1  1 = output enable asserted on the pad this cycle (equals internal oe register).
REQ-012 busy  output  1  state is not IDLE.
REQ-013 pad  inout  WIDTH  bidirectional pad; driven with out_q when oe_q=1, else high-Z on all bits.

Function
REQ-014 FSM states SHALL be IDLE, TURN_ON, DRIVE, TURN_OFF; a turnaround counter tc of 3 bits.
REQ-015 IDLE & drv_req: TURN_CYCLES=0 -> DRIVE; else -> TURN_ON, tc <= TURN_CYCLES-1.
REQ-016 TURN_ON: drv_req=0 -> IDLE (abort, pad never driven); else tc=0 -> DRIVE; else tc <= tc-1.
REQ-017 DRIVE: drv_req=1 -> stay; drv_req=0 -> TURN_OFF with tc <= TURN_CYCLES-1, or IDLE directly when TURN_CYCLES=0.
REQ-018 TURN_OFF: tc=0 -> IDLE, else tc <= tc-1; drv_req ignored until IDLE is reached.
REQ-019 oe_q SHALL register (next_state==DRIVE) on every clock; pad drive starts one cycle after the edge entering DRIVE and stops one cycle after the edge leaving it.
REQ-020 drv_ack SHALL be combinational: drv_req & (next_state==DRIVE); out_q <= drv_data on each cycle drv_ack=1, otherwise out_q holds.
REQ-021 Back-to-back drive: each cycle in DRIVE with drv_req=1 captures a new word; no bubbles.
REQ-022 Synchroniser: pad -> SYNC_STAGES flops per bit, always running regardless of state; rd_data = final stage.
REQ-023 Settle counter sc (3 bits): cleared whenever state!=IDLE or on the edge entering IDLE; increments in IDLE saturating at SYNC_STAGES; rd_valid = (state==IDLE) & (sc==SYNC_STAGES).
REQ-024 rd_valid SHALL be 0 in TURN_ON, DRIVE, TURN_OFF, and for SYNC_STAGES cycles after entering IDLE, so own driven data never appears valid.
REQ-025 oe_q and out_q SHALL never change pad drive with oe_q high in two consecutive states other than DRIVE (no contention path: oe_q=1 only when state==DRIVE in the previous cycle's next_state).
REQ-026 rst asserted mid-DRIVE SHALL release pad (oe_q=0) on the same edge, with no turnaround.

Reset
REQ-027 On rst: state=IDLE, tc=0, sc=0, oe_q=0, out_q=0, synchroniser flops=0; outputs drv_ack=0, rd_valid=0, bus_dir=0, busy=0, rd_data=0, pad high-Z.
REQ-028 drv_req asserted during rst SHALL be ignored; the FSM leaves IDLE no earlier than the first edge with rst=0.

Verification (WIDTH=8, SYNC_STAGES=2, TURN_CYCLES=2 unless stated)
REQ-029 Reset then pad driven externally 0x5A -> rd_valid rises 2 cycles after rst release, rd_data=0x5A.
REQ-030 drv_req held 4 cycles from IDLE, drv_data 0x11,0x22,... -> 2 TURN_ON cycles, drv_ack high 2 cycles after drv_req, pad shows captured words one cycle after each ack, then 2 high-Z TURN_OFF cycles, rd_valid back after 2 further IDLE cycles.
REQ-031 drv_req pulsed 1 cycle from IDLE -> TURN_ON then IDLE abort; bus_dir stays 0, drv_ack never 1, pad never driven.
REQ-032 TURN_CYCLES=0, drv_req 1 cycle with 0xA5 -> drv_ack same cycle, pad=0xA5 next cycle only, then high-Z; no dead cycles.
REQ-033 rst asserted in DRIVE with pad=0x3C -> next cycle bus_dir=0, pad high-Z, busy=0, rd_valid=0 until 2 IDLE cycles after rst release.
REQ-034 Random drv_req toggling 10k cycles -> checker: bus_dir=1 only in cycles following next_state==DRIVE, rd_valid never 1 while busy=1, ack count equals driven-word count.

Source files
------------

// File: rtl/bidir_bus_ctrl.sv
// Bidirectional pad bus controller.
// Sequences the output enable with dead turnaround cycles at each direction
// change. It also synchronises the pad into the clock domain and flags read
// data valid only after the bus has been released and the synchroniser has
// flushed.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | pad released, synchroniser settling / read data valid
//   TURN_ON  | dead cycles before this block starts driving the pad
//   DRIVE    | pad driven from out_q, one word captured per requesting cycle
//   TURN_OFF | dead cycles after release, requests ignored
module bidir_bus_ctrl #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             drv_req,
   input  logic [WIDTH-1:0] drv_data,
   output logic             drv_ack,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             bus_dir,
   output logic             busy,
   inout  wire  [WIDTH-1:0] pad
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TURN_ON  = 2'd1,
      DRIVE    = 2'd2,
      TURN_OFF = 2'd3
   } state_t;

   // Counter reload value; unused when there are no dead cycles.
   localparam logic [2:0] TC_LOAD = 3'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
   localparam logic [2:0] SC_MAX  = 3'(SYNC_STAGES);
   localparam bit         NO_TURN = (TURN_CYCLES == 0);

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       tc;
   logic [2:0]       tc_nxt;
   logic [2:0]       sc;
   logic             oe_q;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   // Next-state and turnaround counter decode.
   always_comb begin
      state_nxt = state;
      tc_nxt    = tc;
      case (state)
         IDLE: begin
            if (drv_req) begin
               if (NO_TURN) begin
                  state_nxt = DRIVE;
               end else begin
                  state_nxt = TURN_ON;
                  tc_nxt    = TC_LOAD;
               end
            end
         end
         TURN_ON: begin
            if (!drv_req) begin
               state_nxt = IDLE;
            end else if (tc == 3'd0) begin
               state_nxt = DRIVE;
            end else begin
               tc_nxt = tc - 3'd1;
            end
         end
         DRIVE: begin
            if (!drv_req) begin
               if (NO_TURN) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = TURN_OFF;
                  tc_nxt    = TC_LOAD;
               end
            end
         end
         TURN_OFF: begin
            if (tc == 3'd0) begin
               state_nxt = IDLE;
            end else begin
               tc_nxt = tc - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset masks the ack so a request held through reset captures nothing.
   assign drv_ack = !rst && drv_req && (state_nxt == DRIVE);

   // State, counter and pad output registers; reset drops the enable at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tc    <= 3'd0;
         oe_q  <= 1'b0;
         out_q <= '0;
      end else begin
         state <= state_nxt;
         tc    <= tc_nxt;
         oe_q  <= (state_nxt == DRIVE);
         if (drv_ack) begin
            out_q <= drv_data;
         end
      end
   end

   // Pad synchroniser, free running in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= pad;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Settle counter: counts idle cycles until the synchroniser holds only undriven samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sc <= 3'd0;
      end else if (state != IDLE) begin
         sc <= 3'd0;
      end else if (sc != SC_MAX) begin
         sc <= sc + 3'd1;
      end
   end

   assign pad      = oe_q ? out_q : {WIDTH{1'bz}};
   assign rd_data  = sync_q[SYNC_STAGES-1];
   assign rd_valid = (state == IDLE) && (sc == SC_MAX);
   assign bus_dir  = oe_q;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: two instances (two dead cycles / none) share the
// fabric stimulus; each pad has an external driver that takes the bus
// whenever the reference model says the block is not driving.
module tb_bidir_bus_ctrl;
   localparam int W  = 8;
   localparam int SS = 2;
   localparam int TCV [2] = '{2, 0};

   logic         clk = 1'b0;
   logic         rst;
   logic         drv_req;
   logic [W-1:0] drv_data;
   logic [W-1:0] ext_val;
   wire  [W-1:0] pad0;
   wire  [W-1:0] pad1;

   logic         ack_w  [2];
   logic         dir_w  [2];
   logic         busy_w [2];
   logic         rv_w   [2];
   logic [W-1:0] rd_w   [2];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int ack_cnt [2] = '{0, 0};
   int dir_cnt [2] = '{0, 0};

   // Reference model: phase 0 idle, 1 dead-before-drive, 2 driving, 3 dead-after.
   // m_cnt counts dead cycles still to go, including the current one.
   int           m_ph     [2] = '{0, 0};
   int           m_cnt    [2] = '{0, 0};
   int           m_settle [2] = '{0, 0};
   bit           m_oe     [2] = '{1'b0, 1'b0};
   logic [W-1:0] m_out    [2] = '{8'h00, 8'h00};
   logic [W-1:0] m_sync   [2][SS] = '{default: '0};

   always #5 clk = ~clk;

   assign pad0 = m_oe[0] ? {W{1'bz}} : ext_val;
   assign pad1 = m_oe[1] ? {W{1'bz}} : ext_val;

   bidir_bus_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .TURN_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .drv_req(drv_req), .drv_data(drv_data),
      .drv_ack(ack_w[0]), .rd_data(rd_w[0]), .rd_valid(rv_w[0]),
      .bus_dir(dir_w[0]), .busy(busy_w[0]), .pad(pad0));

   bidir_bus_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .TURN_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .drv_req(drv_req), .drv_data(drv_data),
      .drv_ack(ack_w[1]), .rd_data(rd_w[1]), .rd_valid(rv_w[1]),
      .bus_dir(dir_w[1]), .busy(busy_w[1]), .pad(pad1));

   function automatic int next_ph(int k);
      case (m_ph[k])
         0:       return drv_req ? ((TCV[k] == 0) ? 2 : 1) : 0;
         1:       return !drv_req ? 0 : ((m_cnt[k] == 1) ? 2 : 1);
         2:       return drv_req ? 2 : ((TCV[k] == 0) ? 0 : 3);
         default: return (m_cnt[k] == 1) ? 0 : 3;
      endcase
   endfunction

   function automatic int next_cnt(int k);
      if (m_ph[k] == 0 || m_ph[k] == 2) return TCV[k];
      return m_cnt[k] - 1;
   endfunction

   function automatic bit next_drive(int k);
      return !rst && (next_ph(k) == 2);
   endfunction

   function automatic logic [W-1:0] pad_of(int k);
      return (k == 0) ? pad0 : pad1;
   endfunction

   task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
      end
   endtask

   // Model advances on every rising edge using the inputs held across it.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ph[k]     <= 0;
            m_cnt[k]    <= 0;
            m_oe[k]     <= 1'b0;
            m_out[k]    <= '0;
            m_settle[k] <= 0;
            for (int i = 0; i < SS; i++) m_sync[k][i] <= '0;
         end else begin
            m_ph[k]  <= next_ph(k);
            m_cnt[k] <= next_cnt(k);
            m_oe[k]  <= next_drive(k);
            if (drv_req && next_drive(k)) m_out[k] <= drv_data;
            m_settle[k] <= (m_ph[k] != 0) ? 0 : ((m_settle[k] >= SS) ? SS : m_settle[k] + 1);
            m_sync[k][0] <= m_oe[k] ? m_out[k] : ext_val;
            for (int i = 1; i < SS; i++) m_sync[k][i] <= m_sync[k][i-1];
         end
      end
   end

   // Compare every output of both instances against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("drv_ack",  k, 32'(ack_w[k]),  32'(drv_req && next_drive(k)));
            chk("bus_dir",  k, 32'(dir_w[k]),  32'(m_oe[k]));
            chk("busy",     k, 32'(busy_w[k]), 32'(m_ph[k] != 0));
            chk("rd_valid", k, 32'(rv_w[k]),   32'(m_ph[k] == 0 && m_settle[k] == SS));
            chk("rd_data",  k, 32'(rd_w[k]),   32'(m_sync[k][SS-1]));
            chk("pad",      k, 32'(pad_of(k)), 32'(m_oe[k] ? m_out[k] : ext_val));
            chk("valid_while_busy", k, 32'(rv_w[k] && busy_w[k]), 32'd0);
            if (ack_w[k]) ack_cnt[k]++;
            if (dir_w[k]) dir_cnt[k]++;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      drv_req  = 1'b1;
      drv_data = 8'h77;
      ext_val  = 8'h5A;
      nxt();
      chk_en = 1'b1;
      nxt();
      nxt();
      @(negedge clk);
      chk("ack_in_reset", 0, 32'(ack_w[0]), 32'd0);
      chk("busy_in_reset", 0, 32'(busy_w[0]), 32'd0);

      // Release reset with an external 0x5A on the pads.
      nxt();
      rst = 1'b0; drv_req = 1'b0;
      @(negedge clk); chk("rv_release0", 0, 32'(rv_w[0]), 32'd0);
      nxt();
      @(negedge clk); chk("rv_release1", 0, 32'(rv_w[0]), 32'd0);
      nxt();
      @(negedge clk);
      chk("rv_release2", 0, 32'(rv_w[0]), 32'd1);
      chk("rd_5a", 0, 32'(rd_w[0]), 32'h5A);

      // Four-cycle request burst.
      nxt(); drv_req = 1'b1; drv_data = 8'h11;
      @(negedge clk); chk("burst_ack_c0", 0, 32'(ack_w[0]), 32'd0);
      chk("burst_ack_tc0", 1, 32'(ack_w[1]), 32'd1);
      nxt(); drv_data = 8'h22;
      nxt(); drv_data = 8'h33;
      @(negedge clk); chk("burst_ack_c2", 0, 32'(ack_w[0]), 32'd1);
      nxt(); drv_data = 8'h44;
      @(negedge clk);
      chk("burst_dir_c3", 0, 32'(dir_w[0]), 32'd1);
      chk("burst_pad_c3", 0, 32'(pad0), 32'h33);
      nxt(); drv_req = 1'b0;
      @(negedge clk); chk("burst_pad_c4", 0, 32'(pad0), 32'h44);
      nxt();
      @(negedge clk);
      chk("burst_dir_c5", 0, 32'(dir_w[0]), 32'd0);
      chk("burst_busy_c5", 0, 32'(busy_w[0]), 32'd1);
      nxt(); nxt(); nxt();
      @(negedge clk); chk("burst_rv_c8", 0, 32'(rv_w[0]), 32'd0);
      nxt();
      @(negedge clk); chk("burst_rv_c9", 0, 32'(rv_w[0]), 32'd1);

      // One-cycle pulse: abort on the two-dead-cycle unit, single word on the other.
      nxt(); drv_req = 1'b1; drv_data = 8'hA5;
      @(negedge clk);
      chk("pulse_ack", 0, 32'(ack_w[0]), 32'd0);
      chk("pulse_ack", 1, 32'(ack_w[1]), 32'd1);
      nxt(); drv_req = 1'b0;
      @(negedge clk);
      chk("abort_busy", 0, 32'(busy_w[0]), 32'd1);
      chk("abort_ack", 0, 32'(ack_w[0]), 32'd0);
      chk("abort_dir", 0, 32'(dir_w[0]), 32'd0);
      chk("pulse_dir", 1, 32'(dir_w[1]), 32'd1);
      chk("pulse_pad", 1, 32'(pad1), 32'hA5);
      nxt();
      @(negedge clk);
      chk("abort_dir2", 0, 32'(dir_w[0]), 32'd0);
      chk("abort_idle", 0, 32'(busy_w[0]), 32'd0);
      chk("pulse_release", 1, 32'(dir_w[1]), 32'd0);
      nxt(); nxt();

      // Reset while driving 0x3C.
      nxt(); drv_req = 1'b1; drv_data = 8'h3C;
      nxt();
      nxt();
      @(negedge clk); chk("rst_drv_ack", 0, 32'(ack_w[0]), 32'd1);
      nxt(); rst = 1'b1;
      @(negedge clk);
      chk("rst_drv_dir", 0, 32'(dir_w[0]), 32'd1);
      chk("rst_drv_pad", 0, 32'(pad0), 32'h3C);
      nxt(); rst = 1'b0; drv_req = 1'b0;
      @(negedge clk);
      chk("rst_dir", 0, 32'(dir_w[0]), 32'd0);
      chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
      chk("rst_rv0", 0, 32'(rv_w[0]), 32'd0);
      nxt();
      @(negedge clk); chk("rst_rv1", 0, 32'(rv_w[0]), 32'd0);
      nxt();
      @(negedge clk); chk("rst_rv2", 0, 32'(rv_w[0]), 32'd1);

      // Random request toggling with occasional resets.
      for (int n = 0; n < 10000; n++) begin
         nxt();
         if ($urandom_range(0, 3) == 0) drv_req = ~drv_req;
         drv_data = 8'($urandom);
         ext_val  = 8'($urandom);
         rst      = ($urandom_range(0, 999) == 0);
      end
      nxt(); rst = 1'b0; drv_req = 1'b0;
      repeat (10) nxt();
      @(negedge clk);
      chk("ack_vs_driven", 0, 32'(ack_cnt[0]), 32'(dir_cnt[0]));
      chk("ack_vs_driven", 1, 32'(ack_cnt[1]), 32'(dir_cnt[1]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
